// File: rtl/pll_sup_pkg.sv
// Shared types, defaults and helpers for the SDRAM PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StWaitLock  = 3'd0,
        StStabilize = 3'd1,
        StPllRst    = 3'd2,
        StHold      = 3'd3,
        StReady     = 3'd4,
        StLost      = 3'd5,
        StFailed    = 3'd6
    } pll_state_e;

    // Defaults for the SDRAM rPLL fed from the 27 MHz board clock.
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 27000;
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_HOLD_CYCLES    = 64;
    localparam int unsigned DEF_MAX_RETRIES    = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous clear to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, retries a PLL that fails to lock, and sequences the
// downstream SDRAM reset/ready. Runs on the free-running PLL reference clock.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_async,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count,
    output logic [2:0] state_dbg
);

    localparam int unsigned CntW =
        clog2(max4(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES, HOLD_CYCLES)) + 1;
    localparam int unsigned RetryW = clog2(MAX_RETRIES + 1) + 1;

    localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]   HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    pll_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [RetryW-1:0] retries_q;
    logic              lock_s;

    logic       pll_reset_d, rst_out_d, ready_d, fail_d;
    logic [7:0] loss_count_d;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d  (lock_async),
        .q  (lock_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitLock;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLock: begin
                // A lock arriving on the timeout cycle takes priority over a retry.
                if (lock_s) begin
                    state_d = StStabilize;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = (retries_q < RetryMax) ? StPllRst : StFailed;
                end
            end
            StStabilize: begin
                if (!lock_s) state_d = StWaitLock;
                else if (cnt_q == StableLast) state_d = StHold;
            end
            StPllRst: begin
                if (cnt_q == PllRstLast) state_d = StWaitLock;
            end
            StHold: begin
                if (!lock_s) state_d = StWaitLock;
                else if (cnt_q == HoldLast) state_d = StReady;
            end
            StReady: begin
                if (!lock_s) state_d = StLost;
            end
            StLost:   state_d = StWaitLock;
            StFailed: state_d = StFailed;
            default:  state_d = StWaitLock;
        endcase
    end

    // Shared state-duration counter; holds at all-ones in the open-ended states.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            retries_q <= '0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StWaitLock && state_d == StPllRst) begin
                retries_q <= retries_q + 1'b1;
            end else if (state_q == StHold && state_d == StReady) begin
                retries_q <= '0;
            end
        end
    end

    // Outputs decode the next state so they register in step with state_q.
    always_comb begin
        pll_reset_d  = (state_d == StPllRst);
        rst_out_d    = (state_d != StReady);
        ready_d      = (state_d == StReady);
        fail_d       = (state_d == StFailed);
        loss_count_d = loss_count;
        if (state_d == StLost && loss_count != 8'hFF) begin
            loss_count_d = loss_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pll_reset  <= 1'b0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            pll_reset  <= pll_reset_d;
            rst_out    <= rst_out_d;
            ready      <= ready_d;
            fail       <= fail_d;
            loss_count <= loss_count_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_async = 1'b0;
    logic       pll_reset, rst_out, ready, fail;
    logic [7:0] loss_count;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .LOCK_TIMEOUT  (20),
        .PLL_RST_CYCLES(4),
        .HOLD_CYCLES   (5),
        .MAX_RETRIES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock_async(lock_async),
        .pll_reset (pll_reset),
        .rst_out   (rst_out),
        .ready     (ready),
        .fail      (fail),
        .loss_count(loss_count),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst low just after a reset edge; the next edge is cycle 1.
    task automatic apply_reset();
        rst = 1'b1;
        lock_async = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready === 1'b1) begin
                cycles = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected from release with lock held low: pulses on cycles 20-23 and 44-47, fail from 68.
    task automatic run_no_lock(input string tag);
        logic exp_prst, exp_fail;
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_prst = ((k >= 20) && (k <= 23)) || ((k >= 44) && (k <= 47));
            exp_fail = (k >= 68);
            n_cmp++;
            if (pll_reset !== exp_prst) begin
                n_bad++;
                $display("FAIL %s_pll_reset cyc %0d: got %b want %b", tag, k, pll_reset, exp_prst);
            end
            n_cmp++;
            if (fail !== exp_fail) begin
                n_bad++;
                $display("FAIL %s_fail cyc %0d: got %b want %b", tag, k, fail, exp_fail);
            end
            n_cmp++;
            if (rst_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_rst_out cyc %0d: got %b want 1", tag, k, rst_out);
            end
        end
        n_cmp++;
        if (state_dbg !== 3'd6) begin
            n_bad++;
            $display("FAIL %s_state: got %0d want 6", tag, state_dbg);
        end
        repeat (10) tick();
        n_cmp++;
        if (fail !== 1'b1 || state_dbg !== 3'd6 || pll_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_sticky: got fail=%b state=%0d pll_reset=%b want 1/6/0", tag, fail,
                     state_dbg, pll_reset);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lock_async = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({pll_reset, rst_out, ready, fail} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0100", {pll_reset, rst_out, ready, fail});
        end
        n_cmp++;
        if (loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_loss_count: got %0d want 0", loss_count);
        end
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_clean_lock();
        bit saw_prst;
        apply_reset();
        repeat (2) tick();
        lock_async = 1'b1;
        saw_prst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (pll_reset === 1'b1) saw_prst = 1'b1;
            if (k == 15) begin
                n_cmp++;
                if (ready !== 1'b0 || rst_out !== 1'b1) begin
                    n_bad++;
                    $display("FAIL clean_early: got ready=%b rst_out=%b want 0/1", ready, rst_out);
                end
            end
        end
        n_cmp++;
        if (ready !== 1'b1 || rst_out !== 1'b0 || state_dbg !== 3'd4) begin
            n_bad++;
            $display("FAIL clean_ready: got ready=%b rst_out=%b state=%0d want 1/0/4", ready,
                     rst_out, state_dbg);
        end
        n_cmp++;
        if (saw_prst !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_no_pll_reset: got pulse=%b want 0", saw_prst);
        end
    endtask

    task automatic test_no_lock();
        apply_reset();
        run_no_lock("nolock");
    endtask

    task automatic test_bounce();
        apply_reset();
        lock_async = 1'b1;
        repeat (5) tick();
        lock_async = 1'b0;
        tick();
        lock_async = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL bounce_dropout: got state %0d want 0", state_dbg);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 3'd1) begin
            n_bad++;
            $display("FAIL bounce_restab: got state %0d want 1", state_dbg);
        end
        repeat (12) tick();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_early: got ready %b want 0", ready);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || rst_out !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_ready: got ready=%b rst_out=%b want 1/0", ready, rst_out);
        end
        n_cmp++;
        if (loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL bounce_loss_count: got %0d want 0", loss_count);
        end
    endtask

    task automatic test_loss();
        int cycles;
        bit ok;
        logic [7:0] exp_loss;
        apply_reset();
        lock_async = 1'b1;
        wait_ready(cycles, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL loss_initial_ready: got timeout want ready");
        end
        for (int i = 0; i < 300; i++) begin
            lock_async = 1'b0;
            tick();
            tick();
            if (i == 0) begin
                n_cmp++;
                if (ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL loss_latency_early: got ready %b want 1", ready);
                end
            end
            tick();
            n_cmp++;
            if (rst_out !== 1'b1 || ready !== 1'b0) begin
                n_bad++;
                $display("FAIL loss_drop iter %0d: got rst_out=%b ready=%b want 1/0", i, rst_out,
                         ready);
            end
            exp_loss = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            n_cmp++;
            if (loss_count !== exp_loss) begin
                n_bad++;
                $display("FAIL loss_count iter %0d: got %0d want %0d", i, loss_count, exp_loss);
            end
            lock_async = 1'b1;
            wait_ready(cycles, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL loss_relock iter %0d: got timeout want ready", i);
                break;
            end
            if (i == 0) begin
                n_cmp++;
                if (cycles != 16) begin
                    n_bad++;
                    $display("FAIL loss_relock_latency: got %0d want 16", cycles);
                end
            end
        end
        n_cmp++;
        if (loss_count !== 8'd255) begin
            n_bad++;
            $display("FAIL loss_saturate: got %0d want 255", loss_count);
        end
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        repeat (20) tick();
        n_cmp++;
        if (pll_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pulse_start: got %b want 1", pll_reset);
        end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({pll_reset, rst_out, ready, fail} !== 4'b0100 || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got flags=%b state=%0d want 0100/0",
                     {pll_reset, rst_out, ready, fail}, state_dbg);
        end
        rst = 1'b0;
        run_no_lock("midrst_retry");
    endtask

    task automatic test_timeout_race();
        bit saw_prst;
        int cycles;
        bit ok;
        apply_reset();
        repeat (17) tick();
        lock_async = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL race_waiting: got state %0d want 0", state_dbg);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 3'd1 || pll_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL race_stabilize: got state=%0d pll_reset=%b want 1/0", state_dbg,
                     pll_reset);
        end
        saw_prst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pll_reset === 1'b1) saw_prst = 1'b1;
            if (ready === 1'b1) break;
        end
        n_cmp++;
        if (saw_prst !== 1'b0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL race_ready: got pulse=%b ready=%b want 0/1", saw_prst, ready);
        end
        wait_ready(cycles, ok);
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_no_lock();
        test_bounce();
        test_loss();
        test_reset_mid_pulse();
        test_timeout_race();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
